// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 integer divider for DIV / DIVU.
// One quotient bit is produced per clock, MSB first. The result is returned
// as {remainder, quotient}, where HI = [2W-1:W] and LO = [W-1:0].
//
// Ports:
//   clk       clock; all state changes happen on the rising edge
//   rst       synchronous active-high reset
//   start_i   request; held high until ready_o is seen
//   signed_i  1 = two's complement (DIV), 0 = unsigned (DIVU); sampled in IDLE
//   a_i, b_i  dividend / divisor; sampled with start_i in IDLE
//   annul_i   flush; aborts any operation in flight
//   result_o  {remainder, quotient}; zero except in END
//   ready_o   result valid
//   stall_o   pipeline hold request
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem;       // partial remainder
  logic [WIDTH-1:0]   quo;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvs;       // divisor magnitude
  logic               q_neg, r_neg;
  logic [2*WIDTH-1:0] result;

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   rem_next, quo_next;

  assign accept = start_i && !annul_i;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign mag_a  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b  = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Trial subtract: the remainder is always below the divisor, so the
  // shifted value fits WIDTH+1 bits and diff[WIDTH] is a valid sign bit.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; annul_i wins over start_i everywhere
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (b_i == '0) ? DIVZERO : ON;
      DIVZERO: state_next = annul_i ? IDLE : END;
      ON: begin
        if (annul_i)   state_next = IDLE;
        else if (last) state_next = END;
      end
      END:     if (!start_i || annul_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready_o  = (state == END);
    result_o = ready_o ? result : '0;
    stall_o  = !rst && accept && (state != END);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && (b_i != '0)) begin
            quo   <= mag_a;
            dvs   <= mag_b;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            r_neg <= signed_i && a_i[WIDTH-1];
          end
        end
        DIVZERO: result <= '0;
        ON: begin
          if (!annul_i) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CW'(1);
            // Final iteration folds in the sign correction
            if (last)
              result <= {r_neg ? -rem_next : rem_next,
                         q_neg ? -quo_next : quo_next};
          end
        end
        END: if (!start_i || annul_i) result <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: an arithmetic reference model plus a
// cycle-level expectation of ready/stall/result, compared every cycle,
// together with directed vectors carrying hand-computed results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .result_o (result_o),
    .ready_o  (ready_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: truncating division on wide signed integers.
  function automatic logic [63:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint qa, qb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
    end else begin
      qa = longint'({32'd0, a});
      qb = longint'({32'd0, b});
    end
    q = qa / qb;
    r = qa % qb;
    return {r[31:0], q[31:0]};
  endfunction

  // Cycle-level model: busy for a fixed number of cycles, then done.
  typedef enum int {P_IDLE, P_BUSY, P_DONE} phase_t;
  phase_t      ph = P_IDLE;
  int          left = 0;
  logic [63:0] exp_res = '0;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph = P_IDLE;
      model_on = 1'b1;
    end else begin
      case (ph)
        P_IDLE: if (start_i && !annul_i) begin
          exp_res = ref_div(a_i, b_i, signed_i);
          left = (b_i == 32'd0) ? 1 : 32;
          ph = P_BUSY;
        end
        P_BUSY: begin
          if (annul_i) ph = P_IDLE;
          else begin
            left--;
            if (left == 0) ph = P_DONE;
          end
        end
        P_DONE: if (!start_i || annul_i) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic        e_ready, e_stall;
    logic [63:0] e_result;
    if (model_on) begin
      e_ready  = (ph == P_DONE);
      e_result = e_ready ? exp_res : 64'd0;
      e_stall  = !rst && start_i && !annul_i && (ph != P_DONE);
      checks++;
      if (ready_o !== e_ready) begin
        errors++;
        $display("FAIL ready t=%0t got %0b want %0b", $time, ready_o, e_ready);
      end
      checks++;
      if (stall_o !== e_stall) begin
        errors++;
        $display("FAIL stall t=%0t got %0b want %0b", $time, stall_o, e_stall);
      end
      checks++;
      if (result_o !== e_result) begin
        errors++;
        $display("FAIL result t=%0t got %h want %h", $time, result_o, e_result);
      end
    end
  end

  // Start an operation, measure the cycle in which ready appears (cycle n is
  // the interval ending at edge n, edge 0 being the accepting edge), check the
  // hand-computed result, hold one cycle in END, then release.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int exp_lat,
                         input logic [63:0] want, input string name);
    int got;
    @(posedge clk); #1;
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
    @(posedge clk);
    got = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        got = n;
        break;
      end
    end
    checks++;
    if (got != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, got, exp_lat);
    end
    checks++;
    if (result_o !== want) begin
      errors++;
      $display("FAIL %s value got %h want %h", name, result_o, want);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    bit seen;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0;
    a_i = '0; b_i = '0; annul_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || stall_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs got %0b %0b %h want 0 0 0", ready_o, stall_o, result_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(32'd100,        32'd7,          1'b0, 33, 64'h00000002_0000000E, "u100_7");
    run_div(32'hFFFFFFF9,   32'd2,          1'b1, 33, 64'hFFFFFFFF_FFFFFFFD, "s_m7_2");
    run_div(32'd7,          32'hFFFFFFFE,   1'b1, 33, 64'h00000001_FFFFFFFD, "s_7_m2");
    run_div(32'h80000000,   32'hFFFFFFFF,   1'b1, 33, 64'h00000000_80000000, "s_ovf");
    run_div(32'hFFFFFFFF,   32'd1,          1'b0, 33, 64'h00000000_FFFFFFFF, "u_max_1");
    run_div(32'hFFFFFFF9,   32'd2,          1'b0, 33, 64'h00000001_7FFFFFFC, "u_big_2");
    run_div(32'd12345,      32'd0,          1'b0, 2,  64'd0,                 "u_div0");
    run_div(32'hFFFFFF00,   32'd0,          1'b1, 2,  64'd0,                 "s_div0");

    // Annul in the tenth ON cycle
    @(posedge clk); #1;
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL annul_no_ready got 1 want 0");
    end
    run_div(32'd100, 32'd7, 1'b0, 33, 64'h00000002_0000000E, "after_annul");

    // Reset in the fifth ON cycle, start kept high throughout
    @(posedge clk); #1;
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL rst_midop got %0b %h want 0 0", ready_o, result_o);
    end
    @(posedge clk);
    got = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        got = n;
        break;
      end
    end
    checks++;
    if (got != 33) begin
      errors++;
      $display("FAIL rst_restart latency got %0d want 33", got);
    end
    checks++;
    if (result_o !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL rst_restart value got %h want 000000020000000e", result_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
